score_readback: RTL and testbench

- Reader side of the reaction-time score register file.
- The game FSM writes 13-bit scores into addresses 1..N and keeps the entry count N in address 0. This block walks those entries.
- On a show request it reads the count, then reads each stored score in turn. Each score is presented on the display outputs for a fixed dwell time.
- While walking, it accumulates the best (minimum) score and the running sum for the summary display.

---
 rtl/score_readback.sv | 210 +++++++++++++++++++++
 tb/tb_score_readback.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/score_readback.sv
// Reader side of the reaction-time score register file: walks entries 1..N, shows each for
// DWELL_CYCLES cycles, and accumulates best and sum. Optional divider: SCORE_READBACK_AVERAGE_EN.
module score_readback #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int MAX_ENTRIES  = 7
) (
    input  logic        Clock,
    input  logic        buttonReset,
    input  logic        buttonShow,
    input  logic [12:0] ReadData,
    output logic [2:0]  ReadAddress,
    output logic [12:0] displayScore,
    output logic [2:0]  displayIndex,
    output logic        displayValid,
    output logic [12:0] bestScore,
    output logic [15:0] sumScores,
    output logic [12:0] averageScore,
    output logic        busy,
    output logic        done
);

    localparam int              CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]      N_MAX    = 3'(MAX_ENTRIES);
    localparam logic [12:0]     BEST_INIT = 13'h1FFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_SHOW,
`ifdef SCORE_READBACK_AVERAGE_EN
        S_AVG,
`endif
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic             btn_q;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [12:0]      disp_score_q, disp_score_d;
    logic [2:0]       disp_idx_q, disp_idx_d;
    logic [12:0]      best_q, best_d;
    logic [15:0]      sum_q, sum_d;

    logic       start;
    logic [2:0] n_clamp;

    assign start   = buttonShow & ~btn_q;
    assign n_clamp = (ReadData[2:0] > N_MAX) ? N_MAX : ReadData[2:0];

`ifdef SCORE_READBACK_AVERAGE_EN
    // Restoring divider: remainder is always below N (<= 7), so 3 bits hold it.
    logic [2:0]  div_rem_q, div_rem_d;
    logic [15:0] div_quo_q, div_quo_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [12:0] avg_q, avg_d;
    logic [3:0]  rem_shift;
    logic        rem_ge;
    logic [15:0] quo_next;

    assign rem_shift = {div_rem_q, div_quo_q[15]};
    assign rem_ge    = (rem_shift >= {1'b0, n_q});
    assign quo_next  = {div_quo_q[14:0], rem_ge};
`endif

    // NOTE: every output and _d signal gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        disp_score_d = disp_score_q;
        disp_idx_d   = disp_idx_q;
        best_d       = best_q;
        sum_d        = sum_q;
        ReadAddress  = 3'd0;
        displayValid = 1'b0;
        done         = 1'b0;
`ifdef SCORE_READBACK_AVERAGE_EN
        div_rem_d = div_rem_q;
        div_quo_d = div_quo_q;
        div_cnt_d = div_cnt_q;
        avg_d     = avg_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    best_d  = BEST_INIT;
                    sum_d   = 16'd0;
`ifdef SCORE_READBACK_AVERAGE_EN
                    avg_d   = 13'd0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                n_d = n_clamp;
                if (n_clamp == 3'd0) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = 3'd1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                ReadAddress  = idx_q;
                disp_score_d = ReadData;
                disp_idx_d   = idx_q;
                sum_d        = sum_q + {3'b000, ReadData};
                if (ReadData < best_q) begin
                    best_d = ReadData;
                end
                state_d = S_SHOW;
            end
            S_SHOW: begin
                ReadAddress  = idx_q;
                displayValid = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == n_q) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_READ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
`ifdef SCORE_READBACK_AVERAGE_EN
                if (n_q != 3'd0) begin
                    div_rem_d = 3'd0;
                    div_quo_d = sum_q;
                    div_cnt_d = 4'd0;
                    state_d   = S_AVG;
                end
`endif
            end
`ifdef SCORE_READBACK_AVERAGE_EN
            S_AVG: begin
                div_quo_d = quo_next;
                div_rem_d = rem_ge ? 3'(rem_shift - {1'b0, n_q}) : rem_shift[2:0];
                div_cnt_d = div_cnt_q + 4'd1;
                if (div_cnt_q == 4'd15) begin
                    // Mean of 13-bit scores never exceeds 8191, so the quotient fits.
                    avg_d   = 13'(quo_next);
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (buttonReset) begin
            state_q      <= S_IDLE;
            btn_q        <= 1'b0;
            idx_q        <= 3'd0;
            n_q          <= 3'd0;
            cnt_q        <= '0;
            disp_score_q <= 13'd0;
            disp_idx_q   <= 3'd0;
            best_q       <= BEST_INIT;
            sum_q        <= 16'd0;
`ifdef SCORE_READBACK_AVERAGE_EN
            div_rem_q    <= 3'd0;
            div_quo_q    <= 16'd0;
            div_cnt_q    <= 4'd0;
            avg_q        <= 13'd0;
`endif
        end else begin
            state_q      <= state_d;
            btn_q        <= buttonShow;
            idx_q        <= idx_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            disp_score_q <= disp_score_d;
            disp_idx_q   <= disp_idx_d;
            best_q       <= best_d;
            sum_q        <= sum_d;
`ifdef SCORE_READBACK_AVERAGE_EN
            div_rem_q    <= div_rem_d;
            div_quo_q    <= div_quo_d;
            div_cnt_q    <= div_cnt_d;
            avg_q        <= avg_d;
`endif
        end
    end

    assign displayScore = disp_score_q;
    assign displayIndex = disp_idx_q;
    assign bestScore    = best_q;
    assign sumScores    = sum_q;
    assign busy         = (state_q != S_IDLE);
`ifdef SCORE_READBACK_AVERAGE_EN
    assign averageScore = avg_q;
`else
    assign averageScore = 13'd0;
`endif

endmodule

// File: tb/tb_score_readback.sv
// Self-checking bench for score_readback: a cycle schedule derived from the walk rules is
// compared against the DUT every cycle, with results checked against a min/sum model.
module tb_score_readback;

    localparam int D    = 4;
    localparam int MAXN = 7;
`ifdef SCORE_READBACK_AVERAGE_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        show;
    logic [12:0] rf [0:7];
    logic [12:0] rd;
    logic [2:0]  addr;
    logic [12:0] disp_score, best, avg;
    logic [2:0]  disp_idx;
    logic        disp_valid, busy, done;
    logic [15:0] sum;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    always_comb rd = rf[addr];

    score_readback #(.DWELL_CYCLES(D), .MAX_ENTRIES(MAXN)) dut (
        .Clock(clk), .buttonReset(rst), .buttonShow(show), .ReadData(rd),
        .ReadAddress(addr), .displayScore(disp_score), .displayIndex(disp_idx),
        .displayValid(disp_valid), .bestScore(best), .sumScores(sum),
        .averageScore(avg), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset_values();
        check("rst_addr", 32'(addr), 0);
        check("rst_score", 32'(disp_score), 0);
        check("rst_index", 32'(disp_idx), 0);
        check("rst_valid", 32'(disp_valid), 0);
        check("rst_best", 32'(best), 32'h1FFF);
        check("rst_sum", 32'(sum), 0);
        check("rst_avg", 32'(avg), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
    endtask

    function automatic int model_n();
        int m = int'(rf[0][2:0]);
        return (m > MAXN) ? MAXN : m;
    endfunction

    function automatic bit show_level(input int j, input int hold, input bit repulse);
        return (j < hold) && !(repulse && (j == 5 || j == 6));
    endfunction

    // One walk: the start is sampled at the edge after the first negedge; cycle c counts states after it.
    task automatic run_walk(input int hold, input bit repulse);
        int n, f, last_busy, last_c, k, p;
        int exp_best, exp_sum, exp_avg;
        bit exp_read, exp_show;
        n = model_n();
        exp_best = 13'h1FFF;
        exp_sum  = 0;
        for (int i = 1; i <= n; i++) begin
            if (int'(rf[i]) < exp_best) exp_best = int'(rf[i]);
            exp_sum += int'(rf[i]);
        end
        exp_avg   = (AVG_EN && n > 0) ? exp_sum / n : 0;
        f         = 1 + n * (D + 1);
        last_busy = (AVG_EN && n > 0) ? f + 16 : f;
        last_c    = ((last_busy > hold) ? last_busy : hold) + 3;

        @(negedge clk);
        show = 1'b1;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            exp_read = 1'b0;
            exp_show = 1'b0;
            k = 0;
            if (c >= 1 && c < f) begin
                p = (c - 1) % (D + 1);
                k = (c - 1) / (D + 1) + 1;
                exp_read = (p == 0);
                exp_show = (p != 0);
            end
            check("busy", 32'(busy), 32'(c <= last_busy));
            check("done", 32'(done), 32'(c == f));
            check("valid", 32'(disp_valid), 32'(exp_show));
            if (c == 0) check("fetch_addr", 32'(addr), 0);
            if (exp_read) check("read_addr", 32'(addr), 32'(k));
            if (exp_show) begin
                check("score", 32'(disp_score), 32'(rf[k]));
                check("index", 32'(disp_idx), 32'(k));
            end
            show = show_level(c + 1, hold, repulse);
        end
        check("best", 32'(best), 32'(exp_best));
        check("sum", 32'(sum), 32'(exp_sum));
        check("avg", 32'(avg), 32'(exp_avg));
        if (n > 0) begin
            check("held_score", 32'(disp_score), 32'(rf[n]));
            check("held_index", 32'(disp_idx), 32'(n));
        end
    endtask

    initial begin
        rst  = 1'b1;
        show = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 13'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Basic three-entry walk with a single-cycle start pulse.
        rf[0] = 13'd3; rf[1] = 13'd120; rf[2] = 13'd85; rf[3] = 13'd200;
        run_walk(1, 1'b0);

        // Empty register file.
        rf[0] = 13'd0;
        run_walk(1, 1'b0);

        // Count field 7 with upper bits set: clamps/masks to seven entries.
        rf[0] = 13'h00F;
        for (int i = 1; i < 8; i++) rf[i] = 13'($urandom);
        run_walk(1, 1'b0);

        // Held button plus a second rising edge while busy: exactly one walk.
        rf[0] = 13'd3; rf[1] = 13'd120; rf[2] = 13'd85; rf[3] = 13'd200;
        run_walk(100, 1'b1);

        // Reset during SHOW of entry 2, then a clean walk.
        @(negedge clk);
        show = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            show = 1'b0;
        end
        check("mid_valid", 32'(disp_valid), 1);
        check("mid_index", 32'(disp_idx), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        run_walk(1, 1'b0);

        if (AVG_EN) begin
            rf[0] = 13'd4; rf[1] = 13'd100; rf[2] = 13'd101; rf[3] = 13'd102; rf[4] = 13'd8191;
            run_walk(1, 1'b0);
            check("avg_2123", 32'(avg), 2123);
        end

        // Randomized contents and start-pulse widths.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = 13'($urandom);
            run_walk(int'($urandom_range(1, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
